// File: rtl/a2d_sequencer.sv
// -----------------------------------------------------------------------------
// a2d_sequencer
//
// Command-side driver for A2D_intf. Sweeps a masked subset of the eight
// ADC128S channels in ascending order. Each conversion gets one strt_cnv pulse,
// and the sequencer then waits for cnv_cmplt. Each 12-bit result, optionally
// inverted, is stored in a per-channel register file.
//
// A conversion that never completes sets a sticky timeout flag. A one-cycle
// sweep_done pulse marks the end of every full sweep. A configurable idle gap
// separates consecutive sweeps.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   en         in   1   level, 1 = run continuous sweeps
//   ch_mask    in   8   channels to convert, latched at sweep start
//   clr_err    in   1   synchronous clear of tmo_err
//   strt_cnv   out  1   one-cycle conversion start pulse
//   chnnl      out  3   channel under conversion, stable through cnv_cmplt
//   cnv_cmplt  in   1   conversion done pulse
//   res        in  12   conversion result, valid with cnv_cmplt
//   rd_ch      in   3   read select
//   rd_data    out 12   stored value of channel rd_ch (combinational mux)
//   valid      out  8   bit i set once channel i holds a result
//   busy       out  1   sequencer is not idle
//   sweep_done out  1   one-cycle pulse after each completed sweep
//   tmo_err    out  1   sticky conversion timeout flag
// -----------------------------------------------------------------------------
module a2d_sequencer #(
   parameter int INV_RES    = 1,
   parameter int TIMEOUT    = 1024,
   parameter int GAP_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [7:0]  ch_mask,
   input  logic        clr_err,
   output logic        strt_cnv,
   output logic [2:0]  chnnl,
   input  logic        cnv_cmplt,
   input  logic [11:0] res,
   input  logic [2:0]  rd_ch,
   output logic [11:0] rd_data,
   output logic [7:0]  valid,
   output logic        busy,
   output logic        sweep_done,
   output logic        tmo_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      GAP   = 2'd3
   } state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES);

   // Returns {found, index} for the lowest set bit of mask at or above floor_i.
   // Scanning downwards lets the lowest qualifying bit overwrite higher ones.
   function automatic logic [3:0] first_set_from(input logic [7:0] mask,
                                                 input logic [3:0] floor_i);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i] && (4'(i) >= floor_i)) begin
            r = {1'b1, 3'(i)};
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   state_t      state_r, state_nxt_s;
   logic [15:0] cnt_r, cnt_nxt_s;
   logic [7:0]  mask_r, mask_nxt_s;
   logic [2:0]  chnnl_r, chnnl_nxt_s;
   logic        strt_cnv_r;
   logic        busy_r;
   logic        sweep_done_r, done_nxt_s;
   logic        tmo_err_r, tmo_set_s;
   logic        wr_en_s;
   logic [7:0]  valid_r;
   logic [11:0] data_r [8];
   logic [11:0] wr_data_s;
   logic [3:0]  first_s;
   logic [3:0]  next_s;

   // Value written to the register file; the ADC data path may be inverted.
   assign wr_data_s = (INV_RES != 0) ? ~res : res;

   // Lowest channel of a fresh mask, and next channel above the current one.
   assign first_s = first_set_from(ch_mask, 4'd0);
   assign next_s  = first_set_from(mask_r, {1'b0, chnnl_r} + 4'd1);

   // Next-state, counter, channel and event decode.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      mask_nxt_s  = mask_r;
      chnnl_nxt_s = chnnl_r;
      wr_en_s     = 1'b0;
      tmo_set_s   = 1'b0;
      done_nxt_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (en && first_s[3]) begin
               mask_nxt_s  = ch_mask;
               chnnl_nxt_s = first_s[2:0];
               state_nxt_s = START;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         START: begin
            cnt_nxt_s   = 16'd0;
            state_nxt_s = WAIT;
         end
         WAIT: begin
            // Completion beats a simultaneous timeout.
            if (cnv_cmplt) begin
               wr_en_s = 1'b1;
            end else if (cnt_r == TMO_LAST) begin
               tmo_set_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + 16'd1;
            end
            if (cnv_cmplt || (cnt_r == TMO_LAST)) begin
               if (!en) begin
                  state_nxt_s = IDLE;
               end else if (next_s[3]) begin
                  chnnl_nxt_s = next_s[2:0];
                  state_nxt_s = START;
               end else begin
                  // GAP always spends its first cycle alongside sweep_done,
                  // so a new strt_cnv follows sweep_done by GAP_CYCLES+1.
                  done_nxt_s  = 1'b1;
                  cnt_nxt_s   = 16'd0;
                  state_nxt_s = GAP;
               end
            end else begin
               state_nxt_s = WAIT;
            end
         end
         GAP: begin
            if (cnt_r == GAP_LAST) begin
               if (en && first_s[3]) begin
                  mask_nxt_s  = ch_mask;
                  chnnl_nxt_s = first_s[2:0];
                  state_nxt_s = START;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else begin
               cnt_nxt_s   = cnt_r + 16'd1;
               state_nxt_s = GAP;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Control state, counters and registered handshake/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         cnt_r        <= 16'd0;
         mask_r       <= 8'd0;
         chnnl_r      <= 3'd0;
         strt_cnv_r   <= 1'b0;
         busy_r       <= 1'b0;
         sweep_done_r <= 1'b0;
         tmo_err_r    <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         cnt_r        <= cnt_nxt_s;
         mask_r       <= mask_nxt_s;
         chnnl_r      <= chnnl_nxt_s;
         strt_cnv_r   <= (state_nxt_s == START);
         busy_r       <= (state_nxt_s != IDLE);
         sweep_done_r <= done_nxt_s;
         if (tmo_set_s) begin
            tmo_err_r <= 1'b1;
         end else if (clr_err) begin
            tmo_err_r <= 1'b0;
         end else begin
            tmo_err_r <= tmo_err_r;
         end
      end
   end

   // Per-channel result register file and valid flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= 8'd0;
         for (int i = 0; i < 8; i++) begin
            data_r[i] <= 12'd0;
         end
      end else if (wr_en_s) begin
         data_r[chnnl_r]  <= wr_data_s;
         valid_r[chnnl_r] <= 1'b1;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign strt_cnv   = strt_cnv_r;
   assign chnnl      = chnnl_r;
   assign busy       = busy_r;
   assign sweep_done = sweep_done_r;
   assign tmo_err    = tmo_err_r;
   assign valid      = valid_r;
   assign rd_data    = data_r[rd_ch];

endmodule

// File: tb/tb_a2d_sequencer.sv
// -----------------------------------------------------------------------------
// tb_a2d_sequencer
//
// Directed, self-checking bench for a2d_sequencer. A small A2D_intf model
// answers each strt_cnv after adc_dly cycles with res = 12'h0F0 + channel. It
// can also withhold the answer for one channel. The model logs every started
// channel and counts sweep_done pulses.
// -----------------------------------------------------------------------------
module tb_a2d_sequencer;

   localparam int TMO = 32;
   localparam int GAP = 16;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [7:0]  ch_mask;
   logic        clr_err;
   logic        strt_cnv;
   logic [2:0]  chnnl;
   logic        cnv_cmplt;
   logic [11:0] res;
   logic [2:0]  rd_ch;
   logic [11:0] rd_data;
   logic [7:0]  valid;
   logic        busy;
   logic        sweep_done;
   logic        tmo_err;

   int n_checks;
   int n_fail;

   // ADC model controls and logs
   int         adc_dly;
   logic       withhold_en;
   logic [2:0] withhold_ch;
   logic [2:0] strt_ch_q [$];
   int         done_cnt;

   typedef struct packed {
      logic [2:0]  rd_ch;
      logic [11:0] exp_data;
   } rd_vec_t;

   rd_vec_t rd_tbl [8];

   a2d_sequencer #(
      .INV_RES   (1),
      .TIMEOUT   (TMO),
      .GAP_CYCLES(GAP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .ch_mask   (ch_mask),
      .clr_err   (clr_err),
      .strt_cnv  (strt_cnv),
      .chnnl     (chnnl),
      .cnv_cmplt (cnv_cmplt),
      .res       (res),
      .rd_ch     (rd_ch),
      .rd_data   (rd_data),
      .valid     (valid),
      .busy      (busy),
      .sweep_done(sweep_done),
      .tmo_err   (tmo_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // A2D_intf model plus start/done monitor, all on the falling edge.
   initial begin : adc_model
      logic       pend;
      int         cd;
      logic [2:0] pch;
      pend      = 1'b0;
      cd        = 0;
      pch       = 3'd0;
      cnv_cmplt = 1'b0;
      res       = 12'd0;
      forever begin
         @(negedge clk);
         cnv_cmplt = 1'b0;
         if (!rst_n) begin
            pend = 1'b0;
         end else if (pend) begin
            if (cd <= 1) begin
               cnv_cmplt = 1'b1;
               res       = 12'h0F0 + {9'd0, pch};
               pend      = 1'b0;
            end else begin
               cd = cd - 1;
            end
         end
         if (rst_n && strt_cnv) begin
            strt_ch_q.push_back(chnnl);
            pch  = chnnl;
            cd   = adc_dly;
            pend = !(withhold_en && (chnnl == withhold_ch));
         end
         if (rst_n && sweep_done) begin
            done_cnt = done_cnt + 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_logs();
      strt_ch_q.delete();
      done_cnt = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      en    = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (!sweep_done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(sweep_done), 32'd1);
   endtask

   task automatic wait_strt_ch(input string name, input logic [2:0] ch, input int budget);
      int n;
      n = 0;
      while (!(strt_cnv && chnnl == ch) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(strt_cnv && chnnl == ch), 32'd1);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(busy), 32'd0);
   endtask

   task automatic read_ch(input string name, input logic [2:0] ch, input logic [11:0] exp);
      rd_ch = ch;
      #1;
      check(name, 32'(rd_data), 32'(exp));
   endtask

   initial begin : main
      int n;
      n_checks = 0;
      n_fail   = 0;
      done_cnt = 0;
      // ~(12'h0F0 + ch) hand computed
      rd_tbl[0] = '{rd_ch: 3'd0, exp_data: 12'hF0F};
      rd_tbl[1] = '{rd_ch: 3'd1, exp_data: 12'hF0E};
      rd_tbl[2] = '{rd_ch: 3'd2, exp_data: 12'hF0D};
      rd_tbl[3] = '{rd_ch: 3'd3, exp_data: 12'hF0C};
      rd_tbl[4] = '{rd_ch: 3'd4, exp_data: 12'hF0B};
      rd_tbl[5] = '{rd_ch: 3'd5, exp_data: 12'hF0A};
      rd_tbl[6] = '{rd_ch: 3'd6, exp_data: 12'hF09};
      rd_tbl[7] = '{rd_ch: 3'd7, exp_data: 12'hF08};

      rst_n       = 1'b0;
      en          = 1'b0;
      ch_mask     = 8'h00;
      clr_err     = 1'b0;
      rd_ch       = 3'd0;
      adc_dly     = 3;
      withhold_en = 1'b0;
      withhold_ch = 3'd0;
      #2;
      check("rst strt_cnv", 32'(strt_cnv), 32'd0);
      check("rst chnnl", 32'(chnnl), 32'd0);
      check("rst valid", 32'(valid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst sweep_done", 32'(sweep_done), 32'd0);
      check("rst tmo_err", 32'(tmo_err), 32'd0);
      check("rst rd_data", 32'(rd_data), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // ---- full sweep, all channels ----
      clear_logs();
      ch_mask = 8'hFF;
      en      = 1'b1;
      wait_done("t1 sweep_done", 500);
      #1;
      check("t1 busy in gap", 32'(busy), 32'd1);
      check("t1 done count", 32'(done_cnt), 32'd1);
      check("t1 n_strt", 32'(strt_ch_q.size()), 32'd8);
      for (int i = 0; i < 8 && i < strt_ch_q.size(); i++) begin
         check("t1 chnnl order", 32'(strt_ch_q[i]), 32'(i));
      end
      check("t1 valid", 32'(valid), 32'hFF);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!strt_cnv && n < 100);
      check("t1 gap spacing", 32'(n), 32'(GAP + 1));
      check("t1 new sweep ch", 32'(chnnl), 32'd0);
      en = 1'b0;
      wait_idle("t1 idle", 200);
      for (int i = 0; i < 8; i++) begin
         read_ch("t1 rd_data", rd_tbl[i].rd_ch, rd_tbl[i].exp_data);
      end

      // ---- sparse mask 0x81 ----
      do_reset();
      clear_logs();
      ch_mask = 8'h81;
      en      = 1'b1;
      wait_done("t2 sweep_done", 300);
      #1;
      check("t2 n_strt", 32'(strt_ch_q.size()), 32'd2);
      if (strt_ch_q.size() == 2) begin
         check("t2 first ch", 32'(strt_ch_q[0]), 32'd0);
         check("t2 second ch", 32'(strt_ch_q[1]), 32'd7);
      end else begin
         check("t2 strt log", 32'(strt_ch_q.size()), 32'd2);
      end
      check("t2 valid", 32'(valid), 32'h81);
      en = 1'b0;
      wait_idle("t2 idle", 100);

      // ---- timeout on channel 3 ----
      do_reset();
      clear_logs();
      withhold_en = 1'b1;
      withhold_ch = 3'd3;
      ch_mask     = 8'h18;
      en          = 1'b1;
      wait_strt_ch("t3 strt ch3", 3'd3, 100);
      repeat (TMO - 1) @(negedge clk);
      check("t3 tmo_err early", 32'(tmo_err), 32'd0);
      repeat (2) @(negedge clk);
      check("t3 tmo_err set", 32'(tmo_err), 32'd1);
      wait_done("t3 sweep_done", 200);
      #1;
      check("t3 n_strt", 32'(strt_ch_q.size()), 32'd2);
      if (strt_ch_q.size() == 2) begin
         check("t3 moved to ch4", 32'(strt_ch_q[1]), 32'd4);
      end else begin
         check("t3 strt log", 32'(strt_ch_q.size()), 32'd2);
      end
      check("t3 valid", 32'(valid), 32'h10);
      read_ch("t3 rd ch3", 3'd3, 12'h000);
      read_ch("t3 rd ch4", 3'd4, 12'hF0B);
      check("t3 tmo sticky", 32'(tmo_err), 32'd1);
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("t3 clr_err", 32'(tmo_err), 32'd0);
      en          = 1'b0;
      withhold_en = 1'b0;
      wait_idle("t3 idle", 200);

      // ---- completion on exactly the timeout cycle ----
      do_reset();
      clear_logs();
      adc_dly = TMO;
      ch_mask = 8'h04;
      en      = 1'b1;
      wait_done("t4 sweep_done", 300);
      #1;
      check("t4 tmo_err", 32'(tmo_err), 32'd0);
      check("t4 valid", 32'(valid), 32'h04);
      read_ch("t4 rd ch2", 3'd2, 12'hF0D);
      en = 1'b0;
      wait_idle("t4 idle", 200);

      // ---- en dropped during channel-2 conversion ----
      do_reset();
      clear_logs();
      adc_dly = 5;
      ch_mask = 8'hFF;
      en      = 1'b1;
      wait_strt_ch("t5 strt ch2", 3'd2, 100);
      @(negedge clk);
      en = 1'b0;
      wait_idle("t5 idle", 100);
      repeat (10) @(negedge clk);
      #1;
      check("t5 n_strt", 32'(strt_ch_q.size()), 32'd3);
      check("t5 no sweep_done", 32'(done_cnt), 32'd0);
      check("t5 valid", 32'(valid), 32'h07);
      check("t5 busy", 32'(busy), 32'd0);
      read_ch("t5 rd ch2", 3'd2, 12'hF0D);

      // ---- asynchronous reset mid-WAIT, then empty mask ----
      clear_logs();
      en = 1'b1;
      wait_strt_ch("t6 strt ch1", 3'd1, 100);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      rd_ch = 3'd0;
      #1;
      check("t6 rst busy", 32'(busy), 32'd0);
      check("t6 rst valid", 32'(valid), 32'd0);
      check("t6 rst chnnl", 32'(chnnl), 32'd0);
      check("t6 rst strt", 32'(strt_cnv), 32'd0);
      check("t6 rst rd ch0", 32'(rd_data), 32'd0);
      ch_mask = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
      repeat (12) @(negedge clk);
      #1;
      check("t6 mask0 busy", 32'(busy), 32'd0);
      check("t6 mask0 no strt", 32'(strt_ch_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
